// File: rtl/ipu_result_fifo.sv
// Per-channel detection result queues behind a small bus register window (STATUS/CTRL/DATA).
// Optional feature macro IPU_RESULT_FRAME_EN: tag each entry with a 10-bit frame count in DATA[31:22].

module ipu_result_fifo_ch #(
   parameter int DEPTH = 4,
   parameter int EW    = 21
) (
   input  logic          sys_clk,
   input  logic          rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [EW-1:0] wdata_i,
   output logic [EW-1:0] head_o,
   output logic          nonempty_o,
   output logic          ovf_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]              wr_q, wr_d, rd_q, rd_d;
   logic [DEPTH-1:0][EW-1:0] mem_q;
   logic                     empty, full, do_pop, do_push;

   // Extra wrap bit distinguishes full from empty when the indices match.
   assign empty      = (wr_q == rd_q);
   assign full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop     = pop_i & ~empty & ~flush_i;
   assign do_push    = push_i & (~full | do_pop) & ~flush_i;
   assign ovf_o      = push_i & full & ~do_pop & ~flush_i;
   assign head_o     = mem_q[rd_q[AW-1:0]];
   assign nonempty_o = ~empty;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (flush_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + (AW+1)'(1);
         if (do_pop)  rd_d = rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         mem_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
      end
   end
endmodule

module ipu_result_fifo #(
   parameter logic [31:0] BASE_ADDR = 32'h40000200,
   parameter int          NUM_CH    = 2,
   parameter int          DEPTH     = 4,
   parameter int          COORD_W   = 10,
   localparam int         CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               sys_clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [CH_W-1:0]    in_ch,
   input  logic [COORD_W-1:0] in_row,
   input  logic [COORD_W-1:0] in_col,
   input  logic               in_present,
   input  logic               in_sof,
   input  logic               write_i,
   input  logic               read_i,
   input  logic [31:0]        addr_i,
   input  logic [31:0]        data_i,
   inout  wire  [31:0]        data_o,
   inout  wire                ack_o,
   output logic               irq
);
`ifdef IPU_RESULT_FRAME_EN
   localparam int EW = 11 + 2*COORD_W;
`else
   localparam int EW = 1 + 2*COORD_W;
`endif

   logic [29:0]              off;
   logic                     hit_stat, hit_ctrl, cs, wr_stat, wr_ctrl, flush;
   logic [NUM_CH-1:0]        hit_data, nonempty, ovf_set, w1c;
   logic [NUM_CH-1:0]        en_q, en_d, ovf_q, ovf_d;
   logic                     irq_en_q, irq_en_d, irq_q, irq_d;
   logic [NUM_CH-1:0][EW-1:0] head;
   logic [EW-1:0]            wdata;
   logic [31:0]              rdata;

   assign off      = addr_i[31:2] - BASE_ADDR[31:2];
   assign hit_stat = (off == 30'd0);
   assign hit_ctrl = (off == 30'd1);
   assign cs       = (read_i | write_i) & (hit_stat | hit_ctrl | (|hit_data));
   assign wr_stat  = write_i & hit_stat;
   assign wr_ctrl  = write_i & hit_ctrl;
   assign flush    = wr_ctrl & data_i[8];
   assign w1c      = wr_stat ? data_i[8 +: NUM_CH] : '0;

`ifdef IPU_RESULT_FRAME_EN
   logic [9:0] frame_q;

   // Entry captures the pre-increment count when sof and valid coincide.
   assign wdata = {frame_q, in_row, in_col, in_present};

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n)      frame_q <= '0;
      else if (in_sof) frame_q <= frame_q + 10'd1;
   end
`else
   assign wdata = {in_row, in_col, in_present};
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign hit_data[c] = (off == 30'(4 + c));

      ipu_result_fifo_ch #(.DEPTH(DEPTH), .EW(EW)) u_ch (
         .sys_clk    (sys_clk),
         .rst_n      (rst_n),
         .flush_i    (flush),
         .push_i     (in_valid & (in_ch == CH_W'(c)) & en_q[c]),
         .pop_i      (read_i & hit_data[c]),
         .wdata_i    (wdata),
         .head_o     (head[c]),
         .nonempty_o (nonempty[c]),
         .ovf_o      (ovf_set[c])
      );
   end

   function automatic logic [31:0] fmt(input logic [EW-1:0] e);
      logic [2*COORD_W+1:0] lo;
      lo = {e[2*COORD_W:0], 1'b1};
`ifdef IPU_RESULT_FRAME_EN
      return {e[EW-1 -: 10], 22'(lo)};
`else
      return 32'(lo);
`endif
   endfunction

   always_comb begin
      rdata = '0;
      if (hit_stat) begin
         rdata = 32'(nonempty) | (32'(ovf_q) << 8) | (32'(irq_q) << 16);
      end else if (hit_ctrl) begin
         rdata = 32'(en_q) | (32'(irq_en_q) << 9);
      end else begin
         for (int c = 0; c < NUM_CH; c++)
            if (hit_data[c] && nonempty[c]) rdata = fmt(head[c]);
      end
   end

   assign data_o = cs ? rdata : 'z;
   assign ack_o  = cs ? 1'b1  : 1'bz;

   // A new overflow beats a W1C clear in the same cycle.
   always_comb begin
      en_d     = wr_ctrl ? data_i[NUM_CH-1:0] : en_q;
      irq_en_d = wr_ctrl ? data_i[9] : irq_en_q;
      ovf_d    = flush ? '0 : ((ovf_q & ~w1c) | ovf_set);
      irq_d    = irq_en_q & ((|(nonempty & en_q)) | (|ovf_q));
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q     <= '1;
         irq_en_q <= 1'b0;
         ovf_q    <= '0;
         irq_q    <= 1'b0;
      end else begin
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         ovf_q    <= ovf_d;
         irq_q    <= irq_d;
      end
   end

   assign irq = irq_q;

   logic unused_ok;
   assign unused_ok = &{1'b0, addr_i[1:0], data_i, in_sof};
endmodule

// File: tb/tb_ipu_result_fifo.sv
// Randomized + directed scoreboard bench for ipu_result_fifo against a queue-based reference model.

module tb_ipu_result_fifo;
   localparam logic [31:0] BASE  = 32'h40000200;
   localparam int          DEPTH = 4;

   logic        sys_clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ch, in_present, in_sof;
   logic [9:0]  in_row, in_col;
   logic        write_i, read_i;
   logic [31:0] addr_i, data_i;
   wire  [31:0] data_o;
   wire         ack_o;
   logic        irq;

   ipu_result_fifo #(.BASE_ADDR(BASE), .NUM_CH(2), .DEPTH(DEPTH), .COORD_W(10)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .in_valid(in_valid), .in_ch(in_ch),
      .in_row(in_row), .in_col(in_col), .in_present(in_present), .in_sof(in_sof),
      .write_i(write_i), .read_i(read_i), .addr_i(addr_i), .data_i(data_i),
      .data_o(data_o), .ack_o(ack_o), .irq(irq)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct packed { logic mapped; logic [31:0] d; } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   logic [31:0] mq[2][$];
   logic [1:0]  movf, men;
   logic        mirq_en, mirq;
   logic [9:0]  mframe;
   int          checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic mreset();
      mq[0].delete(); mq[1].delete();
      movf = '0; men = 2'b11; mirq_en = 1'b0; mirq = 1'b0; mframe = '0;
   endtask

   task automatic idle_inputs();
      in_valid = 0; in_ch = 0; in_row = '0; in_col = '0; in_present = 0; in_sof = 0;
      write_i = 0; read_i = 0; addr_i = '0; data_i = '0;
   endtask

   // Issue one cycle with the current inputs and advance the model at the edge.
   task automatic step();
      logic [31:0] off, w;
      logic        flush, nirq;
      logic [1:0]  ne;
      exp_t        e;
      int          ch;
      off = addr_i - BASE;
      ne  = {mq[1].size() != 0, mq[0].size() != 0};
      ch  = (off == 32'd20) ? 1 : 0;
      if (read_i) begin
         e.mapped = 1'b1;
         e.d      = '0;
         case (off)
            32'd0:  e.d = 32'(ne) | (32'(movf) << 8) | (32'(mirq) << 16);
            32'd4:  e.d = 32'(men) | (32'(mirq_en) << 9);
            32'd16, 32'd20: if (mq[ch].size() != 0) e.d = mq[ch][0];
            default: e.mapped = 1'b0;
         endcase
         exp_q.push_back(e);
      end
      flush = write_i && off == 32'd4 && data_i[8];
      nirq  = mirq_en && (((ne & men) != 0) || movf != 0);
      w = 32'h1 | (32'(in_present) << 1) | (32'(in_col) << 2) | (32'(in_row) << 12);
`ifdef IPU_RESULT_FRAME_EN
      w = w | (32'(mframe) << 22);
`endif
      @(posedge sys_clk);
      if (read_i && (off == 32'd16 || off == 32'd20) && mq[ch].size() != 0)
         void'(mq[ch].pop_front());
      if (write_i && off == 32'd0) movf = movf & ~data_i[9:8];
      if (in_valid && men[in_ch] && !flush) begin
         if (mq[in_ch].size() < DEPTH) mq[in_ch].push_back(w);
         else movf[in_ch] = 1'b1;
      end
      if (write_i && off == 32'd4) begin
         men = data_i[1:0]; mirq_en = data_i[9];
      end
      if (flush) begin
         mq[0].delete(); mq[1].delete(); movf = '0;
      end
      if (in_sof) mframe = mframe + 10'd1;
      mirq = nirq;
      #1;
   endtask

   task automatic bus_rd(input logic [31:0] off);
      addr_i = BASE + off; read_i = 1; step(); read_i = 0; addr_i = '0;
   endtask

   task automatic bus_wr(input logic [31:0] off, input logic [31:0] d);
      addr_i = BASE + off; data_i = d; write_i = 1; step(); write_i = 0; addr_i = '0; data_i = '0;
   endtask

   task automatic set_push(input logic ch, input logic [9:0] r, input logic [9:0] c, input logic p);
      in_valid = 1; in_ch = ch; in_row = r; in_col = c; in_present = p;
   endtask

   task automatic push(input logic ch, input logic [9:0] r, input logic [9:0] c, input logic p);
      set_push(ch, r, c, p); step(); in_valid = 0;
   endtask

   task automatic do_reset();
      #2 rst_n = 0;
      mreset();
      @(posedge sys_clk); #1;
      rst_n = 1;
   endtask

   always @(negedge sys_clk) begin
      if (rst_n) begin
         chk("irq", 32'(irq), 32'(mirq));
         if (read_i) begin
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rd_unexpected actual=read required=no_read t=%0t", $time);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.mapped) begin
                  chk("ack", 32'(ack_o === 1'b1), 32'd1);
                  chk("rdata", data_o, mon_e.d);
               end else begin
                  chk("ack_unmapped", 32'(ack_o === 1'b1), 32'd0);
               end
            end
         end
      end
   end

   initial begin
      idle_inputs();
      mreset();
      rst_n = 0;
      repeat (3) @(posedge sys_clk);
      #1 rst_n = 1;

      // reset state
      bus_rd(32'h00); bus_rd(32'h04); bus_rd(32'h10); bus_rd(32'h10);
      bus_rd(32'h08); bus_rd(32'h18);

      // single push and pop, then empty read
      push(0, 10'd5, 10'd9, 1'b1);
      bus_rd(32'h10); bus_rd(32'h10);

      // overflow on ch1, in-order drain, W1C
      for (int i = 0; i < 5; i++) push(1, 10'(i + 1), 10'(100 + i), i[0]);
      bus_rd(32'h00);
      for (int i = 0; i < 5; i++) bus_rd(32'h14);
      bus_rd(32'h00);
      bus_wr(32'h00, 32'h200);
      bus_rd(32'h00);

      // full ch0 with concurrent push+pop, then drain
      for (int i = 0; i < 4; i++) push(0, 10'(i), 10'(i * 3), 1'b1);
      set_push(0, 10'h3ff, 10'h3ff, 1'b1);
      bus_rd(32'h10);
      in_valid = 0;
      bus_rd(32'h00);
      for (int i = 0; i < 5; i++) bus_rd(32'h10);

      // flush coincident with a push
      push(0, 10'd1, 10'd2, 1'b0);
      push(1, 10'd3, 10'd4, 1'b1);
      set_push(0, 10'd7, 10'd7, 1'b1);
      bus_wr(32'h04, 32'h103);
      in_valid = 0;
      bus_rd(32'h00);

      // disabled channel drop, then irq on enabled channel
      bus_wr(32'h04, 32'h201);
      push(1, 10'd8, 10'd8, 1'b1);
      repeat (3) step();
      chk("irq_dropped", 32'(irq), 32'd0);
      push(0, 10'd9, 10'd9, 1'b1);
      repeat (2) step();
      chk("irq_set", 32'(irq), 32'd1);
      bus_rd(32'h00); bus_rd(32'h04); bus_rd(32'h10);
      repeat (2) step();

      // asynchronous reset mid-operation
      push(0, 10'd1, 10'd1, 1'b1);
      push(1, 10'd2, 10'd2, 1'b1);
      do_reset();
      bus_rd(32'h00); bus_rd(32'h10); bus_rd(32'h14); bus_rd(32'h04);

`ifdef IPU_RESULT_FRAME_EN
      for (int i = 0; i < 3; i++) begin in_sof = 1; step(); in_sof = 0; end
      push(0, 10'd4, 10'd4, 1'b1);
      bus_rd(32'h10);
      do_reset();
      for (int i = 0; i < 1024; i++) begin in_sof = 1; step(); in_sof = 0; end
      push(0, 10'd6, 10'd6, 1'b1);
      bus_rd(32'h10);
`endif

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         int r;
         r          = $urandom_range(0, 99);
         in_valid   = $urandom_range(0, 1);
         in_ch      = $urandom_range(0, 1);
         in_row     = 10'($urandom);
         in_col     = 10'($urandom);
         in_present = $urandom_range(0, 1);
         in_sof     = ($urandom_range(0, 7) == 0);
         if (r < 30) begin
            read_i = 1; addr_i = BASE + ($urandom_range(0, 1) ? 32'h14 : 32'h10);
         end else if (r < 38) begin
            read_i = 1; addr_i = BASE;
         end else if (r < 41) begin
            read_i = 1; addr_i = BASE + 32'h04;
         end else if (r < 44) begin
            write_i = 1; addr_i = BASE; data_i = $urandom & 32'h0000_0300;
         end else if (r < 46) begin
            write_i = 1; addr_i = BASE + 32'h04;
            data_i = ($urandom & 32'h200)
                   | (($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0)
                   | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'h3);
         end
         step();
         idle_inputs();
      end
      repeat (2) step();

      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL exp_drain actual=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
